// File: rtl/multicycle_main_ctrl.sv
// multicycle_main_ctrl: main control FSM for the multicycle datapath.
// Sequences FETCH -> DECODE -> execute -> memory -> writeback and drives the
// datapath strobes, mux selects and the 3-bit ALUOp.
// Build option: define ILLEGAL_TRAP_EN to trap undefined opcodes into a
// sticky HALT state; without it they retire as a NOP straight from DECODE.
module multicycle_main_ctrl #(
  parameter int ST_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       ext_zero,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  typedef enum logic [ST_W-1:0] {
    S_FETCH    = ST_W'(0),
    S_DECODE   = ST_W'(1),
    S_MEM_ADDR = ST_W'(2),
    S_MEM_RD   = ST_W'(3),
    S_MEM_WB   = ST_W'(4),
    S_MEM_WR   = ST_W'(5),
    S_R_EXEC   = ST_W'(6),
    S_R_WB     = ST_W'(7),
    S_BRANCH   = ST_W'(8),
    S_JUMP     = ST_W'(9),
    S_I_EXEC   = ST_W'(10),
    S_I_WB     = ST_W'(11),
    S_HALT     = ST_W'(12)
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_is_mem;
  logic w_is_r;
  logic w_is_beq;
  logic w_is_j;
  logic w_is_imm;
  logic w_undef;

  // Classify the held opcode into instruction groups
  always_comb begin
    w_is_mem = 1'b0;
    w_is_r   = 1'b0;
    w_is_beq = 1'b0;
    w_is_j   = 1'b0;
    w_is_imm = 1'b0;
    case (opcode)
      OP_LW, OP_SW:                       w_is_mem = 1'b1;
      OP_R:                               w_is_r   = 1'b1;
      OP_BEQ:                             w_is_beq = 1'b1;
      OP_J:                               w_is_j   = 1'b1;
      OP_ADDI, OP_ADDIU, OP_LUI, OP_ORI:  w_is_imm = 1'b1;
      default: ;
    endcase
    w_undef = ~(w_is_mem | w_is_r | w_is_beq | w_is_j | w_is_imm);
  end

  // Next-state selection; unused encodings fall back to FETCH
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_is_mem)      w_next = S_MEM_ADDR;
        else if (w_is_r)   w_next = S_R_EXEC;
        else if (w_is_beq) w_next = S_BRANCH;
        else if (w_is_j)   w_next = S_JUMP;
        else if (w_is_imm) w_next = S_I_EXEC;
        else begin
`ifdef ILLEGAL_TRAP_EN
          w_next = S_HALT;
`else
          w_next = S_FETCH;
`endif
        end
      end
      S_MEM_ADDR: w_next = (opcode == OP_LW) ? S_MEM_RD :
                           (opcode == OP_SW) ? S_MEM_WR : S_FETCH;
      S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   w_next = S_R_WB;
      S_I_EXEC:   w_next = S_I_WB;
`ifdef ILLEGAL_TRAP_EN
      S_HALT:     w_next = S_HALT;
`endif
      default:    w_next = S_FETCH;
    endcase
  end

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Moore output decode; FETCH/MEM_WR strobes qualified by mem_ready, all
  // outputs held low while rst is asserted
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    ext_zero      = 1'b0;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
`ifndef ILLEGAL_TRAP_EN
        instr_done = w_undef;
`endif
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == OP_LUI) ? 3'b011 :
                    (opcode == OP_ORI) ? 3'b100 : 3'b000;
        ext_zero  = (opcode == OP_ORI);
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_HALT: illegal = 1'b1;
`endif
      default: ;
    endcase
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 3'b000;
      ext_zero      = 1'b0;
      instr_done    = 1'b0;
      illegal       = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// tb_multicycle_main_ctrl: directed vector table plus randomized instruction
// stream checked against a per-instruction step-plan reference model.
module tb_multicycle_main_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, reg_dst, alu_src_a, ext_zero;
  logic       instr_done, illegal;
  logic [1:0] pc_source, alu_src_b;
  logic [2:0] alu_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_main_ctrl #(.ST_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .reg_dst(reg_dst), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .ext_zero(ext_zero), .instr_done(instr_done),
    .illegal(illegal)
  );

  // Output word: {pcw, pcwc, pcs[1:0], iord, mrd, mwr, irw, m2r, rw, rdst,
  //               asa, asb[1:0], aop[2:0], extz, done, ill}
  logic [19:0] dut_word;
  assign dut_word = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read,
                     mem_write, ir_write, mem_to_reg, reg_write, reg_dst,
                     alu_src_a, alu_src_b, alu_op, ext_zero, instr_done, illegal};

  localparam logic [19:0] PCW  = 20'h80000, PCWC = 20'h40000;
  localparam logic [19:0] PCS1 = 20'h10000, PCS2 = 20'h20000;
  localparam logic [19:0] IORD = 20'h08000, MRD  = 20'h04000;
  localparam logic [19:0] MWR  = 20'h02000, IRW  = 20'h01000;
  localparam logic [19:0] M2R  = 20'h00800, RW   = 20'h00400;
  localparam logic [19:0] RDST = 20'h00200, ASA  = 20'h00100;
  localparam logic [19:0] ASB1 = 20'h00040, ASB2 = 20'h00080, ASB3 = 20'h000C0;
  localparam logic [19:0] AOP1 = 20'h00008, AOP2 = 20'h00010;
  localparam logic [19:0] AOP3 = 20'h00018, AOP4 = 20'h00020;
  localparam logic [19:0] EXTZ = 20'h00004, DONE = 20'h00002, ILL = 20'h00001;

  localparam logic [19:0] W_FW    = MRD | ASB1;
  localparam logic [19:0] W_FR    = MRD | ASB1 | IRW | PCW;
  localparam logic [19:0] W_DEC   = ASB3;
  localparam logic [19:0] W_MADDR = ASA | ASB2;
  localparam logic [19:0] W_MRD   = MRD | IORD;
  localparam logic [19:0] W_MWB   = RW | M2R | DONE;
  localparam logic [19:0] W_MWR   = MWR | IORD;
  localparam logic [19:0] W_REX   = ASA | AOP2;
  localparam logic [19:0] W_RWB   = RW | RDST | DONE;
  localparam logic [19:0] W_BR    = ASA | AOP1 | PCWC | PCS1 | DONE;
  localparam logic [19:0] W_J     = PCW | PCS2 | DONE;
  localparam logic [19:0] W_IEX   = ASA | ASB2;
  localparam logic [19:0] W_IWB   = RW | DONE;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI = 6'b001111, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_BAD = 6'b111111;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // Step kinds of an instruction plan
  localparam int K_FETCH = 0, K_DEC = 1, K_MADDR = 2, K_MRD = 3, K_MWB = 4;
  localparam int K_MWR = 5, K_REX = 6, K_RWB = 7, K_BR = 8, K_J = 9;
  localparam int K_IEX = 10, K_IWB = 11;

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J,
                      OP_ADDI, OP_ADDIU, OP_LUI, OP_ORI};
  endfunction

  // Steps after FETCH and DECODE for each instruction; -1 ends the plan
  function automatic int tail_kind(input logic [5:0] op, input int i);
    int t[3];
    t = '{-1, -1, -1};
    case (op)
      OP_LW:  t = '{K_MADDR, K_MRD, K_MWB};
      OP_SW:  t = '{K_MADDR, K_MWR, -1};
      OP_R:   t = '{K_REX, K_RWB, -1};
      OP_BEQ: t = '{K_BR, -1, -1};
      OP_J:   t = '{K_J, -1, -1};
      OP_ADDI, OP_ADDIU, OP_LUI, OP_ORI: t = '{K_IEX, K_IWB, -1};
      default: ;
    endcase
    return t[i];
  endfunction

  function automatic bit waits_mem(input int k);
    return (k == K_FETCH) || (k == K_MRD) || (k == K_MWR);
  endfunction

  function automatic logic [19:0] exp_word(input int k, input logic [5:0] op,
                                           input logic mr);
    case (k)
      K_FETCH: return mr ? W_FR : W_FW;
      K_DEC:   return (is_legal(op) || TRAP) ? W_DEC : (W_DEC | DONE);
      K_MADDR: return W_MADDR;
      K_MRD:   return W_MRD;
      K_MWB:   return W_MWB;
      K_MWR:   return mr ? (W_MWR | DONE) : W_MWR;
      K_REX:   return W_REX;
      K_RWB:   return W_RWB;
      K_BR:    return W_BR;
      K_J:     return W_J;
      K_IEX:   return W_IEX | ((op == OP_LUI) ? AOP3 :
                               (op == OP_ORI) ? (AOP4 | EXTZ) : 20'h0);
      K_IWB:   return W_IWB;
      default: return 20'hFFFFF;
    endcase
  endfunction

  typedef struct {
    logic        r;
    logic [5:0]  op;
    logic        mr;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [5:0] op, input logic mr,
                     input logic [19:0] exp);
    vec_t v;
    v.r = r; v.op = op; v.mr = mr; v.exp = exp;
    vecs.push_back(v);
  endtask

  // One clock cycle: drive, sample at the falling edge, compare
  task automatic cyc(input logic r, input logic [5:0] op, input logic mr,
                     input logic [19:0] exp, input string nm);
    rst = r; opcode = op; mem_ready = mr;
    @(negedge clk);
    checks++;
    if (dut_word !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b (rst=%b op=%b mr=%b)",
               nm, dut_word, exp, r, op, mr);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] ops[10];
    logic [5:0] bad[3];
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ADDIU, OP_LUI,
            OP_ORI, OP_BAD};
    bad = '{6'b111111, 6'b000001, 6'b100000};

    // Reset state: everything low while rst is asserted
    add(1, OP_LW, 1, 20'h0);  add(1, OP_LW, 0, 20'h0);
    // LW, no memory wait: 5 cycles
    add(0, OP_LW, 1, W_FR);   add(0, OP_LW, 1, W_DEC);
    add(0, OP_LW, 0, W_MADDR); add(0, OP_LW, 1, W_MRD);
    add(0, OP_LW, 0, W_MWB);
    // R-type
    add(0, OP_R, 1, W_FR);    add(0, OP_R, 1, W_DEC);
    add(0, OP_R, 1, ASA | AOP2); add(0, OP_R, 0, RW | RDST | DONE);
    // ORI then LUI
    add(0, OP_ORI, 1, W_FR);  add(0, OP_ORI, 1, W_DEC);
    add(0, OP_ORI, 0, ASA | ASB2 | AOP4 | EXTZ); add(0, OP_ORI, 1, W_IWB);
    add(0, OP_LUI, 1, W_FR);  add(0, OP_LUI, 1, W_DEC);
    add(0, OP_LUI, 1, ASA | ASB2 | AOP3); add(0, OP_LUI, 0, W_IWB);
    // BEQ and J
    add(0, OP_BEQ, 1, W_FR);  add(0, OP_BEQ, 1, W_DEC); add(0, OP_BEQ, 0, W_BR);
    add(0, OP_J, 1, W_FR);    add(0, OP_J, 1, W_DEC);   add(0, OP_J, 1, W_J);
    // SW completing in one memory cycle
    add(0, OP_SW, 1, W_FR);   add(0, OP_SW, 1, W_DEC);
    add(0, OP_SW, 1, W_MADDR); add(0, OP_SW, 1, W_MWR | DONE);
    // SW with 3 fetch wait cycles, reset while the store waits
    add(0, OP_SW, 0, W_FW);   add(0, OP_SW, 0, W_FW);   add(0, OP_SW, 0, W_FW);
    add(0, OP_SW, 1, W_FR);   add(0, OP_SW, 1, W_DEC);  add(0, OP_SW, 1, W_MADDR);
    add(0, OP_SW, 0, W_MWR);  add(0, OP_SW, 0, W_MWR);
    add(1, OP_SW, 0, 20'h0);  add(1, OP_SW, 1, 20'h0);
    add(0, OP_R, 0, W_FW);    add(0, OP_R, 1, W_FR);    add(0, OP_R, 1, W_DEC);
    add(0, OP_R, 1, W_REX);   add(0, OP_R, 1, W_RWB);
    // Undefined opcode
    add(0, OP_BAD, 1, W_FR);
    if (TRAP) begin
      add(0, OP_BAD, 1, W_DEC);
      add(0, OP_BAD, 1, ILL);  add(0, OP_BAD, 0, ILL);  add(0, OP_R, 1, ILL);
    end else begin
      add(0, OP_BAD, 1, W_DEC | DONE);
      add(0, OP_BAD, 0, W_FW);
    end
    add(1, OP_R, 1, 20'h0);

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      $display("vec %0d: rst=%b op=%b mr=%b exp=%b", i, vecs[i].r, vecs[i].op,
               vecs[i].mr, vecs[i].exp);
      cyc(vecs[i].r, vecs[i].op, vecs[i].mr, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Randomized instruction stream against the step-plan model
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      int idx, kind, cycles;
      idx = $urandom_range(0, TRAP ? 8 : 9);
      op = (idx == 9) ? bad[$urandom_range(0, 2)] : ops[idx];
      cycles = 0;
      for (int s = 0; s < 5; s++) begin
        kind = (s == 0) ? K_FETCH : (s == 1) ? K_DEC : tail_kind(op, s - 2);
        if (kind < 0) break;
        if (waits_mem(kind)) begin
          int w;
          w = $urandom_range(0, 3);
          for (int j = 0; j < w; j++) begin
            cyc(0, op, 1'b0, exp_word(kind, op, 1'b0), $sformatf("rnd%0d.s%0d.w", n, s));
            cycles++;
          end
          cyc(0, op, 1'b1, exp_word(kind, op, 1'b1), $sformatf("rnd%0d.s%0d", n, s));
        end else begin
          logic mr;
          mr = 1'($urandom_range(0, 1));
          cyc(0, op, mr, exp_word(kind, op, mr), $sformatf("rnd%0d.s%0d", n, s));
        end
        cycles++;
      end
      $display("rnd %0d: op=%b cycles=%0d", n, op, cycles);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
